bin2bcd_seq: RTL and testbench
==============================

// Module: bin2bcd_seq
// PURPOSE
//  Parametrised sequential binary-to-BCD converter (shift-and-add-3 / double-dabble).
//  Generalises the fixed 4-bit combinational converter to any BIN_W, one bit per clock.
//  Sits between binary datapaths and display/UART formatting logic.
//  Uses valid/ready handshakes on both sides.
// PARAMETERS
//  BIN_W   8  width of the unsigned binary input; must be >= 1
//  DIGITS  3  number of BCD output digits; must satisfy 10**DIGITS >= 2**BIN_W
// PORTS
//  clk        in   1         single clock; all logic is on the rising edge
//  rst        in   1         synchronous, active-high reset
//  in_valid   in   1         in_bin is valid
//  in_ready   out  1         block accepts input this cycle
//  in_bin     in   BIN_W     unsigned binary operand
//  out_valid  out  1         out_bcd holds a finished result
//  out_ready  in   1         downstream accepts the result
//  out_bcd    out  4*DIGITS  packed BCD result; digit 0 (units) in bits [3:0]
//  busy       out  1         a conversion is in progress (state SHIFT)
// BEHAVIOUR
//  Reset (rst=1 at an edge): state=IDLE, out_valid=0, out_bcd=0, busy=0, bit counter=0.
//   in_ready=0 while rst=1 and rises in the first cycle after rst deasserts.
//   rst overrides all other inputs, including mid-conversion and during DONE (result discarded).
//  FSM states: IDLE -> SHIFT -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid&&in_ready: latch in_bin, clear BCD scratch, counter=BIN_W, go SHIFT.
//   SHIFT: in_ready=0, busy=1. Each cycle: every scratch digit >=5 gets +3 (all digits in parallel,
//    4-bit arithmetic, no carry between digits); then the {scratch,binary} register shifts left by 1.
//    Counter decrements; on the cycle it moves 1->0, load out_bcd from the post-shift scratch, go DONE.
//   DONE: out_valid=1, in_ready=0. out_bcd is held stable until out_valid&&out_ready.
//    On handshake: out_valid=0 next cycle, go IDLE. No same-cycle bypass into a new accept.
//  Latency: accept at edge N -> out_valid=1 after edge N+BIN_W.
//   Max throughput: one result per BIN_W+2 cycles with out_ready held high.
//  out_bcd is updated only on entry to DONE; between results it keeps the last value.
//  Each output digit is always in 0..9; the unused upper digits are 0.
//  in_valid while in_ready=0 is ignored (no queuing); in_bin sampled only on accept.
//  Input 0 -> all-zero output after full BIN_W cycles (no early-out).
//  Elaboration: $error if 10**DIGITS < 2**BIN_W or BIN_W < 1.
//  Counter width: $clog2(BIN_W+1).
// TESTING
//  T1 BIN_W=8,DIGITS=3: accept 8'd255, out_ready=1 -> out_valid exactly 8 cycles later, out_bcd=12'h255.
//  T2 BIN_W=8: 8'd0 -> 12'h000 after 8 cycles; 8'd99 -> 12'h099; 8'd100 -> 12'h100.
//  T3 Backpressure: 8'd173 with out_ready=0 for 5 cycles -> out_valid and 12'h173 stable, in_ready=0
//     throughout; one-cycle out_ready pulse -> out_valid=0 and in_ready=1 on the next cycle.
//  T4 Reset mid-op: accept 8'd200, assert rst for 1 cycle in the 4th SHIFT cycle -> out_valid=0,
//     out_bcd=0, in_ready=1 after release; next accept of 8'd42 -> 12'h042.
//  T5 BIN_W=4,DIGITS=2: sweep 0..15 -> results match {carry,digit} of the legacy converter, e.g. 4'd13 -> 8'h13.
//  T6 BIN_W=16,DIGITS=5: 16'd65535 -> 20'h65535; back-to-back stream with in_valid held -> results in order,
//     one accept per BIN_W+2 cycles; compare all results against a reference model.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential shift-and-add-3 (double-dabble) binary-to-BCD converter.
// One input bit is consumed per clock; valid/ready handshakes on both sides.
module bin2bcd_seq #(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      in_bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_bcd,
    output logic                  busy
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SH_W  = BCD_W + BIN_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    // True when DIGITS decimal digits can hold every BIN_W-bit value.
    function automatic bit capacity_ok(input int unsigned b, input int unsigned d);
        real r;
        r = 1.0;
        for (int unsigned i = 0; i < b; i++) r = r * 2.0;
        for (int unsigned i = 0; i < d; i++) r = r / 10.0;
        return (b >= 1) && (r <= 1.0);
    endfunction

    if (!capacity_ok(BIN_W, DIGITS)) begin : g_param_check
        $error("bin2bcd_seq: need BIN_W >= 1 and 10**DIGITS >= 2**BIN_W");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [BCD_W-1:0]   bcd_reg;
    logic [BIN_W-1:0]   bin_reg;
    logic [CNT_W-1:0]   cnt;
    logic [BCD_W-1:0]   adj_c;
    logic [SH_W-1:0]    sh_c;
    logic [BCD_W-1:0]   bcd_next;
    logic [BIN_W-1:0]   bin_next;

    // Ready only while idle; held low during reset so nothing is accepted under rst.
    assign in_ready = (state == S_IDLE) && !rst;

    // One double-dabble step: add 3 to every digit >= 5, then shift {scratch,binary} left.
    always_comb begin
        adj_c = bcd_reg;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_reg[4*i +: 4] >= 4'd5) begin
                adj_c[4*i +: 4] = bcd_reg[4*i +: 4] + 4'd3;
            end
        end
        sh_c = {adj_c, bin_reg} << 1;
    end

    assign bcd_next = sh_c[SH_W-1 -: BCD_W];
    assign bin_next = sh_c[BIN_W-1:0];

    // Control FSM, scratch registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            bcd_reg   <= '0;
            bin_reg   <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_bcd   <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        bin_reg <= in_bin;
                        bcd_reg <= '0;
                        cnt     <= CNT_W'(BIN_W);
                        busy    <= 1'b1;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    bcd_reg <= bcd_next;
                    bin_reg <= bin_next;
                    cnt     <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        out_bcd   <= bcd_next;
                        out_valid <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq: three instances (4/8/16-bit) checked against a decimal model.
module tb_bin2bcd_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // 4-bit instance
    logic        rst_4, in_valid_4, in_ready_4, out_valid_4, out_ready_4, busy_4;
    logic [3:0]  in_bin_4;
    logic [7:0]  out_bcd_4;
    // 8-bit instance
    logic        rst_8, in_valid_8, in_ready_8, out_valid_8, out_ready_8, busy_8;
    logic [7:0]  in_bin_8;
    logic [11:0] out_bcd_8;
    // 16-bit instance
    logic        rst_16, in_valid_16, in_ready_16, out_valid_16, out_ready_16, busy_16;
    logic [15:0] in_bin_16;
    logic [19:0] out_bcd_16;

    bin2bcd_seq #(.BIN_W(4), .DIGITS(2)) u4 (
        .clk(clk), .rst(rst_4), .in_valid(in_valid_4), .in_ready(in_ready_4),
        .in_bin(in_bin_4), .out_valid(out_valid_4), .out_ready(out_ready_4),
        .out_bcd(out_bcd_4), .busy(busy_4)
    );
    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u8 (
        .clk(clk), .rst(rst_8), .in_valid(in_valid_8), .in_ready(in_ready_8),
        .in_bin(in_bin_8), .out_valid(out_valid_8), .out_ready(out_ready_8),
        .out_bcd(out_bcd_8), .busy(busy_8)
    );
    bin2bcd_seq #(.BIN_W(16), .DIGITS(5)) u16 (
        .clk(clk), .rst(rst_16), .in_valid(in_valid_16), .in_ready(in_ready_16),
        .in_bin(in_bin_16), .out_valid(out_valid_16), .out_ready(out_ready_16),
        .out_bcd(out_bcd_16), .busy(busy_16)
    );

    // Decimal reference: peel off base-10 digits with plain arithmetic.
    function automatic logic [19:0] ref_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic cur_valid(input int w);
        case (w)
            4:       return out_valid_4;
            8:       return out_valid_8;
            default: return out_valid_16;
        endcase
    endfunction

    function automatic logic [19:0] cur_bcd(input int w);
        case (w)
            4:       return 20'(out_bcd_4);
            8:       return 20'(out_bcd_8);
            default: return out_bcd_16;
        endcase
    endfunction

    // Push one value through an idle instance with out_ready high; report result and latency.
    task automatic run_conv(input int w, input int unsigned v,
                            output logic [19:0] res, output int lat);
        lat = -1;
        res = '0;
        case (w)
            4:       begin in_bin_4  = 4'(v);  in_valid_4  = 1'b1; out_ready_4  = 1'b1; end
            8:       begin in_bin_8  = 8'(v);  in_valid_8  = 1'b1; out_ready_8  = 1'b1; end
            default: begin in_bin_16 = 16'(v); in_valid_16 = 1'b1; out_ready_16 = 1'b1; end
        endcase
        tick;
        in_valid_4 = 1'b0; in_valid_8 = 1'b0; in_valid_16 = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick;
            if (cur_valid(w)) begin
                lat = k;
                res = cur_bcd(w);
                break;
            end
        end
        tick;
    endtask

    task automatic test_reset;
        rst_4 = 1'b1; rst_8 = 1'b1; rst_16 = 1'b1;
        in_valid_4 = 1'b0; in_valid_8 = 1'b0; in_valid_16 = 1'b0;
        out_ready_4 = 1'b0; out_ready_8 = 1'b0; out_ready_16 = 1'b0;
        in_bin_4 = '0; in_bin_8 = '0; in_bin_16 = '0;
        repeat (3) tick;
        vectors++;
        if (in_ready_8 !== 1'b0) begin
            miscompares++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready_8);
        end
        vectors++;
        if ({out_valid_8, busy_8, out_bcd_8} !== 14'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got valid=%b busy=%b bcd=%h want 0/0/000",
                     out_valid_8, busy_8, out_bcd_8);
        end
        rst_4 = 1'b0; rst_8 = 1'b0; rst_16 = 1'b0;
        #1;
        vectors++;
        if ({in_ready_4, in_ready_8, in_ready_16} !== 3'b111) begin
            miscompares++;
            $display("FAIL reset_release_ready: got %b want 111", {in_ready_4, in_ready_8, in_ready_16});
        end
        tick;
    endtask

    task automatic test_max;
        logic [19:0] res;
        int lat;
        run_conv(8, 255, res, lat);
        vectors++;
        if (res[11:0] !== 12'h255) begin
            miscompares++; $display("FAIL max_255_value: got %h want 255", res[11:0]);
        end
        vectors++;
        if (lat !== 8) begin
            miscompares++; $display("FAIL max_255_latency: got %0d want 8", lat);
        end
    endtask

    task automatic test_edges;
        int unsigned vals[3] = '{0, 99, 100};
        logic [11:0] exps[3] = '{12'h000, 12'h099, 12'h100};
        logic [19:0] res;
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_conv(8, vals[i], res, lat);
            vectors++;
            if (res[11:0] !== exps[i] || lat !== 8) begin
                miscompares++;
                $display("FAIL edge_%0d: got %h lat %0d want %h lat 8", vals[i], res[11:0], lat, exps[i]);
            end
        end
    endtask

    task automatic test_random;
        logic [19:0] res, exp_v;
        int lat;
        int unsigned v;
        for (int i = 0; i < 20; i++) begin
            v = $urandom_range(255, 0);
            exp_v = ref_bcd(v);
            run_conv(8, v, res, lat);
            vectors++;
            if (res[11:0] !== exp_v[11:0] || lat !== 8) begin
                miscompares++;
                $display("FAIL random_%0d: got %h lat %0d want %h lat 8", v, res[11:0], lat, exp_v[11:0]);
            end
        end
    endtask

    task automatic test_backpressure;
        int seen;
        out_ready_8 = 1'b0;
        in_bin_8 = 8'd173;
        in_valid_8 = 1'b1;
        tick;
        in_valid_8 = 1'b0;
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            tick;
            if (out_valid_8) begin seen = 1; break; end
        end
        vectors++;
        if (seen != 1) begin
            miscompares++; $display("FAIL bp_result_timeout: got no out_valid want out_valid=1");
        end
        // Offer a competing input while stalled; it must be ignored.
        in_bin_8 = 8'd55;
        in_valid_8 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (out_valid_8 !== 1'b1 || out_bcd_8 !== 12'h173 || in_ready_8 !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold_%0d: got valid=%b bcd=%h ready=%b want 1/173/0",
                         k, out_valid_8, out_bcd_8, in_ready_8);
            end
            tick;
        end
        in_valid_8 = 1'b0;
        out_ready_8 = 1'b1;
        tick;
        out_ready_8 = 1'b0;
        vectors++;
        if (out_valid_8 !== 1'b0 || in_ready_8 !== 1'b1 || out_bcd_8 !== 12'h173) begin
            miscompares++;
            $display("FAIL bp_release: got valid=%b ready=%b bcd=%h want 0/1/173",
                     out_valid_8, in_ready_8, out_bcd_8);
        end
        tick;
        vectors++;
        if (busy_8 !== 1'b0 || out_valid_8 !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_no_stale_accept: got busy=%b valid=%b want 0/0", busy_8, out_valid_8);
        end
    endtask

    task automatic test_reset_mid;
        logic [19:0] res;
        int lat;
        in_bin_8 = 8'd200;
        in_valid_8 = 1'b1;
        out_ready_8 = 1'b1;
        tick;
        in_valid_8 = 1'b0;
        repeat (3) tick;
        vectors++;
        if (busy_8 !== 1'b1 || in_ready_8 !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_busy: got busy=%b ready=%b want 1/0", busy_8, in_ready_8);
        end
        rst_8 = 1'b1;
        tick;
        rst_8 = 1'b0;
        #1;
        vectors++;
        if (out_valid_8 !== 1'b0 || out_bcd_8 !== 12'h000 || in_ready_8 !== 1'b1 || busy_8 !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_state: got valid=%b bcd=%h ready=%b busy=%b want 0/000/1/0",
                     out_valid_8, out_bcd_8, in_ready_8, busy_8);
        end
        tick;
        run_conv(8, 42, res, lat);
        vectors++;
        if (res[11:0] !== 12'h042 || lat !== 8) begin
            miscompares++;
            $display("FAIL midrst_next_42: got %h lat %0d want 042 lat 8", res[11:0], lat);
        end
    endtask

    task automatic test_sweep4;
        logic [19:0] res;
        logic [7:0] legacy;
        int lat;
        for (int v = 0; v < 16; v++) begin
            legacy = {3'b000, (v >= 10) ? 1'b1 : 1'b0, 4'((v >= 10) ? v - 10 : v)};
            run_conv(4, v, res, lat);
            vectors++;
            if (res[7:0] !== legacy || lat !== 4) begin
                miscompares++;
                $display("FAIL sweep4_%0d: got %h lat %0d want %h lat 4", v, res[7:0], lat, legacy);
            end
        end
    endtask

    task automatic test_stream16;
        logic [19:0] res, exp_v;
        int lat, got, cyc;
        bit will_accept;
        int unsigned exp_q[$];
        int acc_cyc[$];
        run_conv(16, 65535, res, lat);
        vectors++;
        if (res !== 20'h65535 || lat !== 16) begin
            miscompares++; $display("FAIL max16: got %h lat %0d want 65535 lat 16", res, lat);
        end
        got = 0;
        cyc = 0;
        out_ready_16 = 1'b1;
        in_bin_16 = 16'($urandom);
        in_valid_16 = 1'b1;
        while (got < 6 && cyc < 400) begin
            will_accept = in_ready_16 && in_valid_16;
            if (will_accept) begin
                exp_q.push_back(int'(in_bin_16));
                acc_cyc.push_back(cyc);
            end
            tick;
            cyc++;
            if (will_accept) in_bin_16 = 16'($urandom);
            if (out_valid_16) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++; $display("FAIL stream_spurious: got %h want no result", out_bcd_16);
                end else begin
                    exp_v = ref_bcd(exp_q.pop_front());
                    if (out_bcd_16 !== exp_v) begin
                        miscompares++;
                        $display("FAIL stream_result_%0d: got %h want %h", got, out_bcd_16, exp_v);
                    end
                end
                got++;
            end
        end
        in_valid_16 = 1'b0;
        vectors++;
        if (got != 6) begin
            miscompares++; $display("FAIL stream_count: got %0d want 6", got);
        end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            vectors++;
            if (acc_cyc[i] - acc_cyc[i-1] != 18) begin
                miscompares++;
                $display("FAIL stream_spacing_%0d: got %0d want 18", i, acc_cyc[i] - acc_cyc[i-1]);
            end
        end
        repeat (2) tick;
    endtask

    initial begin
        test_reset;
        test_max;
        test_edges;
        test_random;
        test_backpressure;
        test_reset_mid;
        test_sweep4;
        test_stream16;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
